// File: rtl/aes128_core_unrolled.sv
// aes128_core_unrolled: FIPS-197 AES-128 encryption core computing
// ROUNDS_PER_CYCLE rounds per clock with an on-the-fly key schedule.
module aes128_core_unrolled #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic [127:0] cyphertext
);
    localparam int LATENCY = 10 / ROUNDS_PER_CYCLE;
    localparam logic [3:0] LAST_RND = 4'(ROUNDS_PER_CYCLE * (LATENCY - 1));
    localparam logic [3:0] RND_STEP = 4'(ROUNDS_PER_CYCLE);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] ct_q, ct_d;
    logic         load_q;
    logic         armed_q;
    logic [127:0] ch_st, ch_rk;
    logic [7:0]   ch_rc;
    logic         start;
    logic         last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] v;
        sq = b;
        v  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            v  = gmul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
               {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // One AES round plus one key expansion step; returns {state, key}.
    function automatic logic [255:0] aes_round(
        input logic [127:0] st,
        input logic [127:0] rk,
        input logic [7:0]   rc,
        input logic         fin
    );
        logic [7:0]   s [16];
        logic [7:0]   m [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [31:0]  t;
        logic [127:0] nk;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[4*c+r] = s[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = m[4*c];
            a1 = m[4*c+1];
            a2 = m[4*c+2];
            a3 = m[4*c+3];
            if (!fin) begin
                m[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                m[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                m[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                m[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        t = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
            ^ {rc, 24'h000000};
        nk[127:96] = rk[127:96] ^ t;
        nk[95:64]  = rk[95:64] ^ nk[127:96];
        nk[63:32]  = rk[63:32] ^ nk[95:64];
        nk[31:0]   = rk[31:0] ^ nk[63:32];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return {o ^ nk, nk};
    endfunction

    // The first clock after reset release never starts a run.
    assign start = load & ~load_q & armed_q;
    assign last  = (rnd_q == LAST_RND);

    assign busy       = busy_q;
    assign done       = done_q;
    assign cyphertext = ct_q;

    // Unrolled round chain from the registered state, key and rcon.
    always_comb begin
        ch_st = state_q;
        ch_rk = rk_q;
        ch_rc = rcon_q;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            {ch_st, ch_rk} = aes_round(ch_st, ch_rk, ch_rc,
                                       (int'(rnd_q) + i) == 9);
            ch_rc = xtime(ch_rc);
        end
    end

    // Next-state logic: accept from IDLE/DONE, finish on the last step.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE, DONE: if (start) fsm_d = RUN;
            RUN:        if (last) fsm_d = DONE;
            default:    fsm_d = IDLE;
        endcase
    end

    // Datapath and flag updates for each state.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ct_d    = ct_q;
        unique case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                state_d = ch_st;
                rk_d    = ch_rk;
                rcon_d  = ch_rc;
                rnd_d   = rnd_q + RND_STEP;
                if (last) begin
                    ct_d   = ch_st;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State register: every flop, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rcon_q  <= 8'h01;
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ct_q    <= '0;
            load_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
            load_q  <= load;
            armed_q <= 1'b1;
        end
    end
endmodule
